// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - parameterised UART receiver with valid/ready word output
// Optional parity check enabled by defining UART_RX_PARITY_EN.
module uart_rx_param #(
    parameter int CLK_PER_BIT = 434,
    parameter int DATA_BITS   = 8,
    parameter int STOP_BITS   = 1,
    parameter int PARITY_ODD  = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int              CW        = $clog2(CLK_PER_BIT);
    localparam logic [CW-1:0]   CNT_MID   = CW'(CLK_PER_BIT / 2 - 1);
    localparam logic [CW-1:0]   CNT_BIT   = CW'(CLK_PER_BIT - 1);
    localparam logic [3:0]      LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]      LAST_STOP = 4'(STOP_BITS - 1);

    if (CLK_PER_BIT < 4 || DATA_BITS < 5 || DATA_BITS > 9 ||
        STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_cfg
        $error("uart_rx_param: parameter out of range");
    end

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_IDLE
    } state_t;

    state_t                 state, state_nxt;
    logic [CW-1:0]          cnt, cnt_nxt;
    logic [3:0]             bit_idx, bit_nxt;
    logic [DATA_BITS-1:0]   shreg, shreg_nxt;
    logic                   rx_meta, rx_sync;
    logic                   bit_tick;
    logic                   word_done;
    logic                   stop_bad;

`ifdef UART_RX_PARITY_EN
    localparam logic PAR_ODD = (PARITY_ODD != 0);
    logic par_bit, par_nxt;
    logic par_calc;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
`ifdef UART_RX_PARITY_EN
            par_bit <= 1'b0;
`endif
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bit_idx <= bit_nxt;
            shreg   <= shreg_nxt;
`ifdef UART_RX_PARITY_EN
            par_bit <= par_nxt;
`endif
        end
    end

    // After the start-bit midpoint every sample lands CLK_PER_BIT cycles later, i.e. mid-bit.
    assign bit_tick = (cnt == CNT_BIT);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        bit_nxt   = bit_idx;
        shreg_nxt = shreg;
        word_done = 1'b0;
        stop_bad  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_nxt   = par_bit;
`endif
        case (state)
            IDLE: begin
                if (!rx_sync) begin
                    state_nxt = START;
                    cnt_nxt   = '0;
                end
            end
            START: begin
                if (cnt == CNT_MID) begin
                    cnt_nxt   = '0;
                    bit_nxt   = '0;
                    state_nxt = rx_sync ? IDLE : DATA;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            DATA: begin
                if (bit_tick) begin
                    cnt_nxt   = '0;
                    shreg_nxt = {rx_sync, shreg[DATA_BITS-1:1]};
                    if (bit_idx == LAST_DATA) begin
                        bit_nxt = '0;
`ifdef UART_RX_PARITY_EN
                        state_nxt = PARITY;
`else
                        state_nxt = STOP;
`endif
                    end else begin
                        bit_nxt = bit_idx + 4'd1;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (bit_tick) begin
                    cnt_nxt   = '0;
                    par_nxt   = rx_sync;
                    state_nxt = STOP;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
`endif
            STOP: begin
                if (bit_tick) begin
                    cnt_nxt = '0;
                    if (!rx_sync) begin
                        stop_bad  = 1'b1;
                        bit_nxt   = '0;
                        state_nxt = WAIT_IDLE;
                    end else if (bit_idx == LAST_STOP) begin
                        word_done = 1'b1;
                        bit_nxt   = '0;
                        state_nxt = IDLE;
                    end else begin
                        bit_nxt = bit_idx + 4'd1;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            WAIT_IDLE: begin
                if (rx_sync) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

`ifdef UART_RX_PARITY_EN
    assign par_calc = ((^shreg) ^ par_bit) != PAR_ODD;
`endif

    // A word arriving while the held word is being accepted replaces it seamlessly.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            frame_err <= stop_bad;
            overrun   <= 1'b0;
            if (word_done) begin
                if (!rx_valid || rx_ready) begin
                    rx_data  <= shreg;
                    rx_valid <= 1'b1;
`ifdef UART_RX_PARITY_EN
                    parity_err <= par_calc;
`endif
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

`ifndef UART_RX_PARITY_EN
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_param.sv
// tb/tb_uart_rx_param.sv - directed bench for uart_rx_param (16 clocks per bit)
module tb_uart_rx_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, rx0, rx_ready0;
    logic [7:0] rx_data0;
    logic       rx_valid0, parity_err0, frame_err0, overrun0;

    logic       rst1, rx1, rx_ready1;
    logic [6:0] rx_data1;
    logic       rx_valid1, parity_err1, frame_err1, overrun1;

    uart_rx_param #(.CLK_PER_BIT(16), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) dut (
        .clk(clk), .rst(rst), .rx(rx0),
        .rx_data(rx_data0), .rx_valid(rx_valid0), .rx_ready(rx_ready0),
        .parity_err(parity_err0), .frame_err(frame_err0), .overrun(overrun0)
    );

    uart_rx_param #(.CLK_PER_BIT(16), .DATA_BITS(7), .STOP_BITS(2), .PARITY_ODD(0)) dut7 (
        .clk(clk), .rst(rst1), .rx(rx1),
        .rx_data(rx_data1), .rx_valid(rx_valid1), .rx_ready(rx_ready1),
        .parity_err(parity_err1), .frame_err(frame_err1), .overrun(overrun1)
    );

`ifdef UART_RX_PARITY_EN
    localparam int DONE_EDGE = 171;
`else
    localparam int DONE_EDGE = 155;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int vcnt0 = 0, ferr0 = 0, ovr0 = 0, vcnt1 = 0, ferr1 = 0;
    logic [7:0] last0 = '0;
    logic       last_perr0 = 1'b0;
    int vb, fb, ob;

    always @(negedge clk) begin
        if (rx_valid0) begin
            vcnt0++;
            last0      = rx_data0;
            last_perr0 = parity_err0;
        end
        if (frame_err0) ferr0++;
        if (overrun0)   ovr0++;
        if (rx_valid1)  vcnt1++;
        if (frame_err1) ferr1++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input int which, input logic b);
        if (which == 0) rx0 = b;
        else            rx1 = b;
        repeat (16) tick;
    endtask

    task automatic send_frame(input int which, input logic [8:0] data, input int nbits,
                              input logic par, input logic stop_val, input int nstop);
        send_bit(which, 1'b0);
        for (int i = 0; i < nbits; i++) send_bit(which, data[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(which, par);
`endif
        for (int i = 0; i < nstop; i++) send_bit(which, stop_val);
    endtask

    initial begin
        rst = 1'b1; rst1 = 1'b1;
        rx0 = 1'b1; rx1 = 1'b1;
        rx_ready0 = 1'b0; rx_ready1 = 1'b0;
        repeat (3) tick;
        check("rst_valid", rx_valid0, 0);
        check("rst_data", rx_data0, 0);
        check("rst_ferr", frame_err0, 0);
        check("rst_ovr", overrun0, 0);
        check("rst_perr", parity_err0, 0);
        check("rst_valid7", rx_valid1, 0);
        rst = 1'b0; rst1 = 1'b0;
        repeat (5) tick;

        // clean frame, consumer always ready
        rx_ready0 = 1'b1;
        vb = vcnt0; fb = ferr0; ob = ovr0;
        send_frame(0, 9'h0A5, 8, 1'b0, 1'b1, 1);
        repeat (4) tick;
        check("a5_valid_cycles", vcnt0 - vb, 1);
        check("a5_data", last0, 8'hA5);
        check("a5_perr", last_perr0, 0);
        check("a5_ferr", ferr0 - fb, 0);
        check("a5_ovr", ovr0 - ob, 0);

        // short low glitch must not start a frame
        vb = vcnt0; fb = ferr0;
        rx0 = 1'b0;
        repeat (5) tick;
        rx0 = 1'b1;
        repeat (30) tick;
        check("glitch_valid", vcnt0 - vb, 0);
        check("glitch_ferr", ferr0 - fb, 0);
        send_frame(0, 9'h03C, 8, 1'b0, 1'b1, 1);
        repeat (4) tick;
        check("3c_valid_cycles", vcnt0 - vb, 1);
        check("3c_data", last0, 8'h3C);

        // bad stop bit, line held low, then recovery
        vb = vcnt0; fb = ferr0;
        send_frame(0, 9'h055, 8, 1'b0, 1'b0, 1);
        repeat (24) tick;
        rx0 = 1'b1;
        repeat (20) tick;
        check("55_ferr_pulses", ferr0 - fb, 1);
        check("55_valid", vcnt0 - vb, 0);
        send_frame(0, 9'h00F, 8, 1'b0, 1'b1, 1);
        repeat (4) tick;
        check("0f_valid_cycles", vcnt0 - vb, 1);
        check("0f_data", last0, 8'h0F);

        // back-pressure: overrun, then completion coinciding with acceptance
        rx_ready0 = 1'b0;
        send_frame(0, 9'h011, 8, 1'b0, 1'b1, 1);
        repeat (4) tick;
        check("11_valid", rx_valid0, 1);
        check("11_data", rx_data0, 8'h11);
        ob = ovr0;
        send_frame(0, 9'h022, 8, 1'b0, 1'b1, 1);
        repeat (4) tick;
        check("ovr_data_held", rx_data0, 8'h11);
        check("ovr_pulses", ovr0 - ob, 1);
        check("ovr_valid", rx_valid0, 1);
        fork
            send_frame(0, 9'h022, 8, 1'b0, 1'b1, 1);
            begin
                repeat (DONE_EDGE - 1) tick;
                rx_ready0 = 1'b1;
                tick;
                rx_ready0 = 1'b0;
            end
        join
        check("same_edge_data", rx_data0, 8'h22);
        check("same_edge_valid", rx_valid0, 1);
        check("same_edge_ovr", ovr0 - ob, 1);
        rx_ready0 = 1'b1;
        tick;
        rx_ready0 = 1'b0;
        check("accept_clears", rx_valid0, 0);

`ifdef UART_RX_PARITY_EN
        send_frame(0, 9'h007, 8, 1'b1, 1'b1, 1);
        repeat (4) tick;
        check("par_good_perr", parity_err0, 0);
        check("par_good_data", rx_data0, 8'h07);
        rx_ready0 = 1'b1; tick; rx_ready0 = 1'b0;
        send_frame(0, 9'h007, 8, 1'b0, 1'b1, 1);
        repeat (4) tick;
        check("par_bad_perr", parity_err0, 1);
        check("par_bad_data", rx_data0, 8'h07);
        rx_ready0 = 1'b1; tick; rx_ready0 = 1'b0;
`endif

        // 7 data bits, 2 stop bits: reset in the middle of data bit 3
        fb = ferr1;
        send_bit(1, 1'b0);
        for (int i = 0; i < 3; i++) send_bit(1, 1'b1);
        rx1 = 1'b1;
        repeat (8) tick;
        rst1 = 1'b1;
        tick;
        rst1 = 1'b0;
        rx1 = 1'b1;
        repeat (40) tick;
        check("rst_mid_valid", rx_valid1, 0);
        check("rst_mid_vcnt", vcnt1, 0);
        check("rst_mid_ferr", ferr1 - fb, 0);
        send_frame(1, 9'h02A, 7, 1'b1, 1'b1, 2);
        repeat (4) tick;
        check("2a_valid", rx_valid1, 1);
        check("2a_data", rx_data1, 7'h2A);
        check("2a_ferr", ferr1 - fb, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_param.md
UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 The block SHALL have parameter CLK_PER_BIT, default 434, clock cycles per bit (minimum 4).
REQ-002 The block SHALL have parameter DATA_BITS, default 8, data bits per frame (5 to 9), LSB first.
REQ-003 The block SHALL have parameter STOP_BITS, default 1, stop bits checked per frame (1 or 2).
REQ-004 The block SHALL have parameter PARITY_ODD, default 0, parity sense (0 even, 1 odd), used only when UART_RX_PARITY_EN is defined.
REQ-005 The block SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-006 The block SHALL have port rst, input, 1, reset: synchronous and active-high.
REQ-007 The block SHALL have port rx, input, 1, asynchronous serial line, idle high.
REQ-008 The block SHALL have port rx_data, output, DATA_BITS, received word held while rx_valid=1.
REQ-009 The block SHALL have port rx_valid, output, 1, word available.
REQ-010 The block SHALL have port rx_ready, input, 1, consumer accepts the word when rx_valid=1 and rx_ready=1 on the same edge.
REQ-011 The block SHALL have port parity_err, output, 1, parity mismatch of the word in rx_data, valid with rx_valid.
REQ-012 The block SHALL have port frame_err, output, 1, one-cycle pulse on a bad stop bit.
REQ-013 The block SHALL have port overrun, output, 1, one-cycle pulse when a completed word is dropped.

Function
REQ-014 rx SHALL pass a 2-flop synchronizer (reset value 1); all sampling uses the synchronized value.
REQ-015 States SHALL be IDLE, START, DATA, PARITY, STOP, WAIT_IDLE; bit counter width $clog2(CLK_PER_BIT).
REQ-016 IDLE -> START when synchronized rx=0; counter cleared.
REQ-017 START SHALL sample at count CLK_PER_BIT/2-1: 1 -> IDLE (glitch, no flags), 0 -> DATA with counter cleared.
REQ-018 DATA, PARITY, STOP SHALL sample once every CLK_PER_BIT cycles (mid-bit), DATA_BITS samples into a shift register LSB first.
REQ-019 After DATA: PARITY if UART_RX_PARITY_EN, else STOP; STOP SHALL sample STOP_BITS bits.
REQ-020 Any stop sample of 0 SHALL discard the word, pulse frame_err for one cycle, enter WAIT_IDLE.
REQ-021 WAIT_IDLE SHALL remain until synchronized rx=1, then IDLE; no start detection meanwhile.
REQ-022 On a good final stop sample the word SHALL load rx_data, rx_valid=1 and parity_err on the next edge, and the FSM SHALL return to IDLE.
REQ-023 rx_valid, rx_data, parity_err SHALL hold until accepted; rx_valid clears on the accepting edge.
REQ-024 A word completing while rx_valid=1 and rx_ready=0 SHALL be dropped, stored word preserved, overrun pulsed one cycle.
REQ-025 A word completing on the same edge as acceptance SHALL be loaded with rx_valid staying 1 and no overrun.
REQ-026 Reception SHALL continue independently of rx_valid/rx_ready.

Reset
REQ-027 With rst=1 at a clock edge: state IDLE, counters 0, shift register 0, synchronizer 1, rx_data 0, rx_valid 0, parity_err 0, frame_err 0, overrun 0.
REQ-028 Reset mid-frame SHALL abandon the frame; no word or flag results from it.

Configuration
REQ-029 Macro UART_RX_PARITY_EN defined: PARITY state samples one bit; parity_err=1 when XOR of data bits and parity bit differs from PARITY_ODD; the word is still delivered.
REQ-030 Macro UART_RX_PARITY_EN undefined: no PARITY state, frames are start+data+stop, parity_err tied 0.

Verification (CLK_PER_BIT=16, DATA_BITS=8, STOP_BITS=1 unless noted)
REQ-031 Frame 0xA5, rx_ready=1 -> rx_valid one cycle, rx_data=0xA5, no flags.
REQ-032 rx low for 5 cycles then high -> no rx_valid, no flags, next frame 0x3C received correctly.
REQ-033 Frame 0x55 with stop bit 0, rx high 40 cycles later -> frame_err one pulse, no rx_valid; following 0x0F received.
REQ-034 rx_ready=0, frames 0x11 then 0x22 -> rx_data=0x11 held, overrun one pulse at 0x22 end; rx_ready at 0x22 completion edge -> rx_data=0x22, no overrun.
REQ-035 UART_RX_PARITY_EN, PARITY_ODD=0, 0x07 with parity 1 -> parity_err=0; parity 0 -> parity_err=1, rx_data=0x07.
REQ-036 DATA_BITS=7, STOP_BITS=2, 0x7F then rst at mid data bit 3 -> rx_valid 0, idle; next 0x2A received.
